// File: rtl/trigger_pkg.sv
// Shared types and defaults for the multi-channel trigger/debounce block.
package trigger_pkg;

  typedef enum logic [2:0] {
    READY   = 3'd0,
    SETTLE  = 3'd1,
    REFRESH = 3'd2,
    BLOCK   = 3'd3,
    HOLD    = 3'd4
  } state_e;

  localparam int unsigned DEF_DIGITS          = 6;
  localparam int unsigned DEF_SETTLE_CYCLES   = 16;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 8176;
  localparam int unsigned DEF_HOLD_CYCLES     = 262144;
  localparam int unsigned DEF_REPEAT_CYCLES   = 65536;
  localparam int unsigned DEF_CNT_W           = 20;

  // A cycle count is usable when it is non-zero and fits the counter.
  function automatic bit cycles_ok(int unsigned c, int unsigned w);
    return (c != 0) && ((w >= 32) || (c < (32'd1 << w)));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make both flops sample the old values,
  // giving a true two-stage chain rather than a single collapsed flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/input_trigger_multi.sv
// Multi-channel edge trigger: inc pulse, delayed refresh pulse, debounce
// lockout and optional hold-to-auto-repeat.
module input_trigger_multi
  import trigger_pkg::*;
#(
  parameter int unsigned DIGITS          = DEF_DIGITS,
  parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIGITS-1:0] trigger,
  input  logic [DIGITS-1:0] enable_mask,
  input  logic              repeat_en,
  output logic              inc_clk,
  output logic [DIGITS-1:0] inc_sel,
  output logic              ref_clk,
  output logic              busy
);

  localparam bit PARAMS_OK = cycles_ok(SETTLE_CYCLES, CNT_W)
                          && cycles_ok(DEBOUNCE_CYCLES, CNT_W)
                          && cycles_ok(HOLD_CYCLES, CNT_W)
                          && cycles_ok(REPEAT_CYCLES, CNT_W);

  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST     = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST   = CNT_W'(REPEAT_CYCLES - 1);

  param_check: assert property (@(posedge clk) PARAMS_OK);

  logic [DIGITS-1:0] s;
  logic [DIGITS-1:0] new_edges;
  logic [DIGITS-1:0] rep_sel;
  logic [CNT_W-1:0]  hold_last;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIGITS-1:0] prev_q, prev_d;
  logic [DIGITS-1:0] held_q, held_d;
  logic              repeating_q, repeating_d;
  logic              inc_q, inc_d;
  logic [DIGITS-1:0] inc_sel_q, inc_sel_d;
  logic              ref_q, ref_d;

  sync_2ff #(.WIDTH(DIGITS)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (trigger),
    .q_o   (s)
  );

  assign new_edges = s & ~prev_q & enable_mask;
  assign rep_sel   = s & held_q & enable_mask;
  assign hold_last = repeating_q ? REPEAT_LAST : HOLD_LAST;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    held_d      = held_q;
    repeating_d = repeating_q;
    inc_d       = 1'b0;
    inc_sel_d   = '0;
    ref_d       = 1'b0;

    unique case (state_q)
      READY: begin
        prev_d = s;
        if (|new_edges) begin
          state_d     = SETTLE;
          inc_d       = 1'b1;
          inc_sel_d   = new_edges;
          held_d      = new_edges;
          repeating_d = 1'b0;
          cnt_d       = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = REFRESH;
          ref_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REFRESH: begin
        state_d = BLOCK;
        cnt_d   = '0;
      end
      BLOCK: begin
        if (cnt_q == DEBOUNCE_LAST) begin
          cnt_d   = '0;
          state_d = (repeat_en && |(s & held_q)) ? HOLD : READY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        prev_d = s;
        // A fresh press outranks the repeat of the channel being held.
        if (|new_edges) begin
          state_d     = SETTLE;
          inc_d       = 1'b1;
          inc_sel_d   = new_edges;
          held_d      = new_edges;
          repeating_d = 1'b0;
          cnt_d       = '0;
        end else if (!repeat_en || !(|(s & held_q))) begin
          state_d = READY;
          cnt_d   = '0;
        end else if (cnt_q == hold_last) begin
          cnt_d = '0;
          if (|rep_sel) begin
            state_d     = SETTLE;
            inc_d       = 1'b1;
            inc_sel_d   = rep_sel;
            held_d      = rep_sel;
            repeating_d = 1'b1;
          end else begin
            state_d = READY;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = READY;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= READY;
      cnt_q       <= '0;
      prev_q      <= '0;
      held_q      <= '0;
      repeating_q <= 1'b0;
      inc_q       <= 1'b0;
      inc_sel_q   <= '0;
      ref_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      held_q      <= held_d;
      repeating_q <= repeating_d;
      inc_q       <= inc_d;
      inc_sel_q   <= inc_sel_d;
      ref_q       <= ref_d;
    end
  end

  assign inc_clk = inc_q;
  assign inc_sel = inc_sel_q;
  assign ref_clk = ref_q;
  assign busy    = (state_q != READY);

endmodule

// File: tb/tb_input_trigger_multi.sv
// Directed bench for input_trigger_multi with a queue of expected inc pulses.
module tb_input_trigger_multi;

  localparam int SETTLE   = 4;
  localparam int DEBOUNCE = 20;
  localparam int HOLD     = 50;
  localparam int REPEAT   = 10;

  typedef struct {
    int         cyc;
    logic [3:0] sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] trigger;
  logic [3:0] enable_mask;
  logic       repeat_en;
  logic       inc_clk;
  logic [3:0] inc_sel;
  logic       ref_clk;
  logic       busy;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   exp_ref_cyc = -1;
  exp_t exp_q[$];

  input_trigger_multi #(
    .DIGITS(4), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEBOUNCE),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .CNT_W(20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .enable_mask (enable_mask),
    .repeat_en   (repeat_en),
    .inc_clk     (inc_clk),
    .inc_sel     (inc_sel),
    .ref_clk     (ref_clk),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_inc(input int c, input logic [3:0] sel);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    exp_q.push_back(e);
  endtask

  // Scoreboard: pops an expectation whenever the DUT emits an inc pulse.
  always @(negedge clk) begin
    exp_t e;
    if (inc_clk === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_inc_sel", 32'(inc_sel), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("inc_cycle", cyc, e.cyc);
        check("inc_sel", 32'(inc_sel), 32'(e.sel));
        exp_ref_cyc = cyc + SETTLE;
      end
    end else begin
      check("idle_inc_sel", 32'(inc_sel), 32'd0);
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        check("missed_inc_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
    if (ref_clk === 1'b1 || cyc == exp_ref_cyc)
      check("ref_clk", 32'(ref_clk), 32'(cyc == exp_ref_cyc));
    check("inc_ref_exclusive", 32'(inc_clk & ref_clk), 32'd0);
  end

  initial begin
    int t, t0, r, busy_cnt, first_busy;

    reset       = 1'b0;
    trigger     = '0;
    enable_mask = 4'b1111;
    repeat_en   = 1'b0;
    step(3);
    check("rst_inc_clk", 32'(inc_clk), 32'd0);
    check("rst_ref_clk", 32'(ref_clk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_inc_sel", 32'(inc_sel), 32'd0);
    reset = 1'b1;

    // 1: idle inputs must leave everything quiet.
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (busy) busy_cnt++;
    end
    check("idle_busy_cycles", busy_cnt, 0);

    // 2: single press, lockout length, release without repeat.
    t = cyc;
    trigger = 4'b0010;
    expect_inc(t + 3, 4'b0010);
    busy_cnt = 0;
    first_busy = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (busy === 1'b1) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (cyc == t + 10) trigger = 4'b0000;
    end
    check("busy_first_cycle", first_busy, t + 3);
    check("busy_length", busy_cnt, SETTLE + 1 + DEBOUNCE);
    step(20);
    check("single_busy_low", 32'(busy), 32'd0);

    // 3: simultaneous edges filtered by the enable mask.
    enable_mask = 4'b1011;
    t = cyc;
    trigger = 4'b0101;
    expect_inc(t + 3, 4'b0001);
    step(40);
    trigger = 4'b0000;
    enable_mask = 4'b1111;
    step(5);

    // 4: press arriving during lockout fires on the first READY cycle.
    t = cyc;
    trigger = 4'b1000;
    expect_inc(t + 3, 4'b1000);
    wait_until(t + 12);
    trigger = 4'b1001;
    expect_inc(t + 29, 4'b0001);
    wait_until(t + 27);
    check("lockout_busy_end", 32'(busy), 32'd1);
    wait_until(t + 28);
    check("first_ready_busy", 32'(busy), 32'd0);
    wait_until(t + 60);
    trigger = 4'b0000;
    step(5);

    // 5: hold-to-repeat, then release back to READY.
    repeat_en = 1'b1;
    t = cyc;
    t0 = t + 3;
    trigger = 4'b0001;
    expect_inc(t0, 4'b0001);
    expect_inc(t0 + SETTLE + DEBOUNCE + 1 + HOLD, 4'b0001);
    expect_inc(t0 + 2 * (SETTLE + DEBOUNCE + 1) + HOLD + REPEAT, 4'b0001);
    expect_inc(t0 + 3 * (SETTLE + DEBOUNCE + 1) + HOLD + 2 * REPEAT, 4'b0001);
    wait_until(t0 + 60);
    check("hold_busy", 32'(busy), 32'd1);
    wait_until(t0 + 150);
    trigger = 4'b0000;
    wait_until(t0 + 169);
    check("repeat_block_busy", 32'(busy), 32'd1);
    wait_until(t0 + 170);
    check("repeat_release_busy", 32'(busy), 32'd0);
    repeat_en = 1'b0;
    step(10);

    // 6: reset mid-SETTLE with the button still held.
    t = cyc;
    trigger = 4'b0100;
    expect_inc(t + 3, 4'b0100);
    wait_until(t + 5);
    reset = 1'b0;
    exp_ref_cyc = -1;
    #1;
    check("midrst_inc_clk", 32'(inc_clk), 32'd0);
    check("midrst_ref_clk", 32'(ref_clk), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_inc_sel", 32'(inc_sel), 32'd0);
    wait_until(t + 8);
    reset = 1'b1;
    r = cyc;
    expect_inc(r + 3, 4'b0100);
    wait_until(r + 40);
    trigger = 4'b0000;
    step(10);

    check("pending_incs", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
